// File: rtl/serial_adder8.sv
// Bit-serial 8-bit adder: A + B + Cin, LSB first, one full-adder cell, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER8_OVF_EN.
module serial_adder8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] S,
  output logic       Cout,
  output logic       V
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] acc;
  logic       c;

  logic       sum_bit;
  logic       carry_nxt;

  always_comb begin
    sum_bit   = ra[0] ^ rb[0] ^ c;
    carry_nxt = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  end

`ifdef SERIAL_ADDER8_OVF_EN
  logic c7_in;
  logic v_r;

  // while cnt==7 the carry register holds the carry into bit 7
  always_comb c7_in = c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= 1'b0;
    end else if (state == ADD && cnt == 3'd7) begin
      v_r <= c7_in ^ carry_nxt;
    end
  end

  assign V = v_r;
`else
  assign V = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      c     <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= A;
            rb    <= B;
            c     <= Cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ADD: begin
          ra  <= {1'b0, ra[7:1]};
          rb  <= {1'b0, rb[7:1]};
          c   <= carry_nxt;
          acc <= {sum_bit, acc[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // final sum bit lands directly in S; acc only holds bits 0..6 here
            S     <= {sum_bit, acc[7:1]};
            Cout  <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
